reg_bank_rw: RTL

//   General-purpose register file for the multicycle MIPS datapath; the consumer end of the

---
 rtl/reg_bank_rw.sv | 104 ++++++++++
 1 files changed

// File: rtl/reg_bank_rw.sv
// ---------------------------------------------------------------------------
// reg_bank_rw
//   General-purpose register file for a multicycle MIPS datapath. One write
//   port fed by the write-back selector, two registered read ports feeding the
//   ALU operand registers A/B. A write and a read of the same index on the same
//   edge return the value being written (bypass), so back-to-back instructions
//   see fresh data.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset (0 = in reset)
//   RegWrite   write enable, sampled on rising clk
//   WriteReg   destination register index
//   WriteData  data to store
//   ReadReg1   read port 1 index (rs)
//   ReadReg2   read port 2 index (rt)
//   ReadData1  registered read data, port 1 (one clock after ReadReg1)
//   ReadData2  registered read data, port 2 (one clock after ReadReg2)
//
// Interface protocol: there is no valid/ready handshake. Every rising edge
// is a transaction: the read indices are always sampled, and the write takes
// effect whenever RegWrite is high. The control FSM is trusted to raise
// RegWrite only in its write-back states.
//
// Reset: all registers clear to 0 except SP_INDEX, which loads SP_INIT; both
// read outputs go to 0 immediately and stay 0 while reset is low.
// ---------------------------------------------------------------------------
module reg_bank_rw #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int SP_INDEX   = 29,
  parameter int SP_INIT    = 227
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic [DATA_WIDTH-1:0] rd2_q, rd2_d;

  logic zero_en;
  logic wr_en;

  // A write to index 0 is dropped entirely when register 0 is hard-wired;
  // this also keeps the bypass from forwarding that dropped value.
  assign zero_en = (ZERO_REG != 0);
  assign wr_en   = RegWrite && !(zero_en && (WriteReg == '0));

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[WriteReg] = WriteData;
    end
  end

  // Read priority: hard-wired zero, then same-edge bypass, then array.
  always_comb begin
    rd1_d = regs_q[ReadReg1];
    if (wr_en && (WriteReg == ReadReg1)) begin
      rd1_d = WriteData;
    end
    if (zero_en && (ReadReg1 == '0)) begin
      rd1_d = '0;
    end

    rd2_d = regs_q[ReadReg2];
    if (wr_en && (WriteReg == ReadReg2)) begin
      rd2_d = WriteData;
    end
    if (zero_en && (ReadReg2 == '0)) begin
      rd2_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? DATA_WIDTH'(SP_INIT) : '0;
      end
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      regs_q <= regs_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
    end
  end

  assign ReadData1 = rd1_q;
  assign ReadData2 = rd2_q;

endmodule
